mersenne_mod_pipe: RTL

Pipelined, streaming reduction modulo the Mersenne number M = 2^W − 1, the parametrised successor to the fixed 13-bit combinational reducer in the masked-arithmetic datapath. It accepts one 2W-bit product per cycle over a valid/ready handshake, folds it to a canonical W-bit residue in two registered stages, and, when configured, accumulates a packet of residues mod M, emitting one sum per packet. It sits between the masked share multipliers and the share-recombination logic.

---
 rtl/mersenne_pkg.sv | 29 ++
 rtl/mersenne_fold.sv | 13 +
 rtl/mersenne_mod_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mersenne_pkg.sv
// Shared types and fold arithmetic for reduction modulo M = 2^W - 1.
// Functions take W at run time so one package serves every instance width.
package mersenne_pkg;

  localparam int unsigned W_DEFAULT = 13;

  typedef logic [W_DEFAULT-1:0]   residue_t;
  typedef logic [2*W_DEFAULT-1:0] product_t;
  typedef logic [W_DEFAULT:0]     fold_sum_t;

  function automatic logic [32:0] mersenne_m(input int unsigned w);
    return (33'd1 << w) - 33'd1;
  endfunction

  // s is a (w+1)-bit sum; the carry re-enters at bit 0 because 2^w == 1 mod M.
  // The result can be at most M, never wider than w bits.
  function automatic logic [31:0] mersenne_fold_fn(input logic [32:0] s, input int unsigned w);
    logic [32:0] m;
    logic [32:0] y;
    m = mersenne_m(w);
    y = (s & m) + ((s >> w) & 33'd1);
    if (y == m) begin
      return 32'd0;
    end else begin
      return y[31:0];
    end
  endfunction

endpackage

// File: rtl/mersenne_fold.sv
// Combinational fold of a (W+1)-bit sum to the canonical residue 0..M-1.
module mersenne_fold
  import mersenne_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W:0]   s,
  output logic [W-1:0] r
);

  assign r = W'(mersenne_fold_fn(33'(s), W));

endmodule

// File: rtl/mersenne_mod_pipe.sv
// Two-stage streaming reducer mod 2^W - 1 with valid/ready on both sides.
// Optional packet accumulation is built when MERSENNE_PIPE_ACC_EN is defined.
module mersenne_mod_pipe
  import mersenne_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data
);

  logic [W:0]   s1_sum_q, s1_sum_d;
  logic         v1_q, v1_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         adv2_s;
  logic         accept_s;
  logic [W-1:0] r_s;

`ifdef MERSENNE_PIPE_ACC_EN
  logic         s1_last_q, s1_last_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W:0]   acc_sum_s;
  logic [W-1:0] acc_fold_s;
`else
  logic         unused_in_last_s;
  assign unused_in_last_s = in_last;
`endif

  assign adv2_s   = !out_valid_q || out_ready;
  assign in_ready = !v1_q || adv2_s;
  assign accept_s = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  mersenne_fold #(.W(W)) u_fold_s2 (
    .s (s1_sum_q),
    .r (r_s)
  );

`ifdef MERSENNE_PIPE_ACC_EN
  assign acc_sum_s = {1'b0, acc_q} + {1'b0, r_s};

  mersenne_fold #(.W(W)) u_fold_acc (
    .s (acc_sum_s),
    .r (acc_fold_s)
  );
`endif

  // Stage 1: capture the first-level fold of an accepted beat.
  always_comb begin
    v1_d     = v1_q;
    s1_sum_d = s1_sum_q;
`ifdef MERSENNE_PIPE_ACC_EN
    s1_last_d = s1_last_q;
`endif
    if (accept_s) begin
      v1_d     = 1'b1;
      s1_sum_d = {1'b0, in_data[2*W-1:W]} + {1'b0, in_data[W-1:0]};
`ifdef MERSENNE_PIPE_ACC_EN
      s1_last_d = in_last;
`endif
    end else if (adv2_s) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2: finish the fold (and accumulate) into the output register.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
`ifdef MERSENNE_PIPE_ACC_EN
    acc_d = acc_q;
`endif
    if (v1_q && adv2_s) begin
`ifdef MERSENNE_PIPE_ACC_EN
      if (s1_last_q) begin
        out_data_d  = acc_fold_s;
        out_valid_d = 1'b1;
        acc_d       = {W{1'b0}};
      end else begin
        acc_d = acc_fold_s;
      end
`else
      out_data_d  = r_s;
      out_valid_d = 1'b1;
`endif
    end else begin
      out_data_d = out_data_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      s1_sum_q    <= {(W+1){1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
`ifdef MERSENNE_PIPE_ACC_EN
      s1_last_q   <= 1'b0;
      acc_q       <= {W{1'b0}};
`endif
    end else begin
      v1_q        <= v1_d;
      s1_sum_q    <= s1_sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef MERSENNE_PIPE_ACC_EN
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
`endif
    end
  end

endmodule
